// File: rtl/des_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_rr_arbiter_if
//  Description : Bundle of source, deserializer and downstream signals around
//                the round-robin deserializer arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_rr_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int BITS  = 8
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] src_bit;
    logic [N_SRC-1:0] grant;
    logic             des_status_out;
    logic             des_data_ready;
    logic [BITS-1:0]  des_data_out;
    logic             des_write_in;
    logic             des_data_in;
    logic             des_ack_in;
    logic [BITS-1:0]  out_data;
    logic [SRC_W-1:0] out_src;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        input  req, src_bit, des_status_out, des_data_ready, des_data_out, out_ready,
        output grant, des_write_in, des_data_in, des_ack_in, out_data, out_src,
               out_valid, busy
    );

    modport slave (
        output req, src_bit, des_status_out, des_data_ready, des_data_out, out_ready,
        input  grant, des_write_in, des_data_in, des_ack_in, out_data, out_src,
               out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/des_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : des_rr_arbiter
//  Description : Round-robin arbiter sharing one deserializer between N_SRC
//                serial sources. Optional WAIT_RDY watchdog with sticky err
//                output: define DES_RR_ARBITER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_rr_arbiter #(
    parameter int N_SRC   = 4,
    parameter int BITS    = 8,
    parameter int TIMEOUT = 32
) (
    input  wire logic         clock_100KHz,
    input  wire logic         reset,
`ifdef DES_RR_ARBITER_TIMEOUT_EN
    output logic              err,
`endif
    des_rr_arbiter_if.master  bus
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [SRC_W-1:0] c_last_src = SRC_W'(N_SRC - 1);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(BITS - 1);

    if (N_SRC < 1 || N_SRC > 8 || BITS < 2 || TIMEOUT < 1) begin : g_param_check
        $error("des_rr_arbiter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT    = 2'd1,
        S_WAIT_RDY = 2'd2,
        S_DELIVER  = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_SRC-1:0] r_grant;
    logic [SRC_W-1:0] r_win;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_write;
    logic             r_ack;
    logic [BITS-1:0]  r_out_data;
    logic [SRC_W-1:0] r_out_src;
    logic             r_out_valid;
    logic             r_busy;
    logic [SRC_W-1:0] w_pick;

`ifdef DES_RR_ARBITER_TIMEOUT_EN
    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;
    assign err = r_err;
`endif

    // First requester at or after the pointer, wrapping around N_SRC.
    function automatic logic [SRC_W-1:0] f_pick(input logic [N_SRC-1:0] req_v,
                                                 input logic [SRC_W-1:0] ptr);
        logic [SRC_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && req_v[idx[SRC_W-1:0]]) begin
                sel   = idx[SRC_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_pick = f_pick(bus.req, r_rr_ptr);

    always_ff @(posedge clock_100KHz) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_win       <= '0;
            r_rr_ptr    <= '0;
            r_bit_cnt   <= '0;
            r_write     <= 1'b0;
            r_ack       <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DES_RR_ARBITER_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((|bus.req) && bus.des_status_out) begin
                        r_grant         <= '0;
                        r_grant[w_pick] <= 1'b1;
                        r_win           <= w_pick;
                        r_bit_cnt       <= '0;
                        r_write         <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        r_grant  <= '0;
                        r_write  <= 1'b0;
                        r_rr_ptr <= (r_win == c_last_src) ? '0 : r_win + 1'b1;
                        r_state  <= S_WAIT_RDY;
`ifdef DES_RR_ARBITER_TIMEOUT_EN
                        r_wd_cnt <= '0;
`endif
                    end
                end
                S_WAIT_RDY: begin
                    if (bus.des_data_ready) begin
                        r_out_data  <= bus.des_data_out;
                        r_out_src   <= r_win;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DELIVER;
                    end
`ifdef DES_RR_ARBITER_TIMEOUT_EN
                    // Watchdog: flush the deserializer and drop the word.
                    else if (r_wd_cnt == c_wd_last) begin
                        r_err   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                S_DELIVER: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_ack       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.des_write_in = r_write;
    assign bus.des_data_in  = r_write ? bus.src_bit[r_win] : 1'b0;
    assign bus.des_ack_in   = r_ack;
    assign bus.out_data     = r_out_data;
    assign bus.out_src      = r_out_src;
    assign bus.out_valid    = r_out_valid;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire
